// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and small helpers for the instruction cache.
package cache_pkg;

  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;

  // Returned on the instruction port whenever the fetch is not serviced.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } icache_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      sat_inc32 = value;
    end else begin
      sat_inc32 = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, single synchronous write port; reset clears
// only the valid bits, tag and data contents are don't-care until filled.
module icache_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IW       = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - 4 - IW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     i_rd_index,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_index,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  // Valid bits: cleared by reset, set when a line is installed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= {NUM_SETS{1'b0}};
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data storage written together on a fill.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits are serviced in the same
// cycle; a miss stalls the PC, fetches the 4-word line over a valid/ready
// request and a single-cycle response pulse, installs it and re-looks up.
module instruction_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetch_valid,
  input  logic [31:0]       i_pc_addr,
  output logic [31:0]       o_instr,
  output logic              o_cache_stall_or_not,
  output logic              o_mem_req_valid,
  output logic [31:0]       o_mem_req_addr,
  input  logic              i_mem_req_ready,
  input  logic              i_mem_resp_valid,
  input  logic [LINE_W-1:0] i_mem_resp_line,
  output logic [31:0]       o_hit_count,
  output logic [31:0]       o_miss_count
);

  localparam int IW    = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 4 - IW;

  icache_state_t r_state;
  icache_state_t w_state_next;

  logic              r_req_valid;
  logic [31:0]       r_req_addr;
  logic [31:0]       r_hit_count;
  logic [31:0]       r_miss_count;

  logic [IW-1:0]     w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_offset;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_line;
  logic              w_hit;
  logic              w_stall;
  logic              w_miss;
  logic              w_fill;
  logic              w_wr_en;
  logic [31:0]       w_word;
  logic              w_unused_pc_bits;

  // Address split of the incoming fetch.
  assign w_offset = i_pc_addr[3:2];
  assign w_index  = i_pc_addr[4+IW-1:4];
  assign w_tag    = i_pc_addr[31:4+IW];

  // Byte-within-word bits carry no information for word fetches.
  assign w_unused_pc_bits = ^i_pc_addr[1:0];

  // A fill that coincides with reset is dropped so no partial line survives.
  assign w_wr_en = w_fill & ~reset;

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IW       (IW),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_wr_en),
    .i_wr_index (r_req_addr[4+IW-1:4]),
    .i_wr_tag   (r_req_addr[31:4+IW]),
    .i_wr_line  (i_mem_resp_line)
  );

  assign w_hit = i_fetch_valid & w_rd_valid & (w_rd_tag == w_tag);

  // Select the addressed word out of the looked-up line.
  always_comb begin
    w_word = w_rd_line[31:0];
    case (w_offset)
      2'd0:    w_word = w_rd_line[31:0];
      2'd1:    w_word = w_rd_line[63:32];
      2'd2:    w_word = w_rd_line[95:64];
      2'd3:    w_word = w_rd_line[127:96];
      default: w_word = w_rd_line[31:0];
    endcase
  end

  // Next-state, stall, miss-detect and fill-strobe decisions.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_fetch_valid && !w_hit) begin
          w_stall      = 1'b1;
          w_miss       = 1'b1;
          w_state_next = REQ;
        end else begin
          w_stall      = 1'b0;
          w_state_next = IDLE;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (i_mem_req_ready) begin
          w_state_next = WAIT;
        end else begin
          w_state_next = REQ;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (i_mem_resp_valid) begin
          w_fill       = 1'b1;
          w_state_next = FILL;
        end else begin
          w_state_next = WAIT;
        end
      end
      FILL: begin
        // The line is installed; the next IDLE cycle re-looks up the PC.
        w_stall      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_stall      = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request register: latch the line address on a miss, hold until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_valid <= 1'b0;
      r_req_addr  <= 32'h0000_0000;
    end else if (w_miss) begin
      r_req_valid <= 1'b1;
      r_req_addr  <= {i_pc_addr[31:4], 4'b0000};
    end else if ((r_state == REQ) && i_mem_req_ready) begin
      r_req_valid <= 1'b0;
    end
  end

  // Saturating hit and miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= 32'h0000_0000;
      r_miss_count <= 32'h0000_0000;
    end else begin
      if ((r_state == IDLE) && w_hit) begin
        r_hit_count <= sat_inc32(r_hit_count);
      end
      if (w_miss) begin
        r_miss_count <= sat_inc32(r_miss_count);
      end
    end
  end

  assign o_cache_stall_or_not = w_stall;
  assign o_instr              = (w_stall || !w_hit) ? NOP_INSTR : w_word;
  assign o_mem_req_valid      = r_req_valid;
  assign o_mem_req_addr       = r_req_addr;
  assign o_hit_count          = r_hit_count;
  assign o_miss_count         = r_miss_count;

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: a memory responder process
// answers line requests, scoreboards hold expected request addresses and
// fetched instructions, and counters are tracked by a small bench model.
module tb_instruction_cache;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic [31:0]  pc_addr;
  logic [31:0]  instr;
  logic         cache_stall_or_not;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_line;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  // Responder controls and state
  int          hold_left    = 0;
  int          resp_delay   = 2;
  int          resp_left    = 0;
  logic        accepted_prev = 1'b0;
  logic [31:0] acc_addr     = 32'h0;
  logic [31:0] pend_addr    = 32'h0;
  logic [31:0] req_exp_v;

  always #5 clk = ~clk;

  instruction_cache #(.NUM_SETS(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_fetch_valid        (fetch_valid),
    .i_pc_addr            (pc_addr),
    .o_instr              (instr),
    .o_cache_stall_or_not (cache_stall_or_not),
    .o_mem_req_valid      (mem_req_valid),
    .o_mem_req_addr       (mem_req_addr),
    .i_mem_req_ready      (mem_req_ready),
    .i_mem_resp_valid     (mem_resp_valid),
    .i_mem_resp_line      (mem_resp_line),
    .o_hit_count          (hit_count),
    .o_miss_count         (miss_count)
  );

  // Backing memory contents: word at byte address a is (a/4)+1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    return {mem_word(la + 32'd12), mem_word(la + 32'd8),
            mem_word(la + 32'd4), mem_word(la)};
  endfunction

  // Memory responder: ready after hold_left REQ cycles, response pulse in the
  // resp_delay-th cycle after acceptance; accepted addresses are scoreboarded.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_line  = 128'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (accepted_prev) begin
        resp_left = resp_delay;
        pend_addr = acc_addr;
      end
      if (resp_left > 0) begin
        if (resp_left == 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_line  = mem_line(pend_addr);
        end
        resp_left = resp_left - 1;
      end
      if (mem_req_valid === 1'b1) begin
        if (hold_left > 0) begin
          mem_req_ready = 1'b0;
          hold_left     = hold_left - 1;
        end else begin
          mem_req_ready = 1'b1;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
      #1;
      accepted_prev = (mem_req_valid === 1'b1) && mem_req_ready;
      if (accepted_prev) begin
        acc_addr = mem_req_addr;
        n_cmp++;
        if (exp_req_q.size() == 0) begin
          n_err++;
          $display("FAIL req_addr: unexpected request to %h", mem_req_addr);
        end else begin
          req_exp_v = exp_req_q.pop_front();
          if (mem_req_addr !== req_exp_v) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", mem_req_addr, req_exp_v);
          end
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    fetch_valid = 1'b0;
    hold_left   = 0;
    tick();
    tick();
    reset      = 1'b0;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
  endtask

  // One fetch from a cycle start: counts stall and request cycles, checks
  // NOP while stalled and the request address, then the serviced word.
  task automatic run_fetch(input logic [31:0] pc, input int exp_stall,
                           input int exp_reqc, input string name);
    int          stalls;
    int          reqc;
    logic [31:0] line_a;
    logic [31:0] want;
    stalls = 0;
    reqc   = 0;
    line_a = {pc[31:4], 4'h0};
    exp_instr_q.push_back(mem_word({pc[31:2], 2'b00}));
    if (exp_stall > 0) begin
      exp_req_q.push_back(line_a);
      exp_misses = exp_misses + 32'd1;
    end
    fetch_valid = 1'b1;
    pc_addr     = pc;
    #1;
    while (cache_stall_or_not !== 1'b0 && stalls < 200) begin
      n_cmp++;
      if (instr !== NOP_INSTR) begin
        n_err++;
        $display("FAIL %s nop: got %h expected %h", name, instr, NOP_INSTR);
      end
      if (mem_req_valid === 1'b1) begin
        reqc++;
        n_cmp++;
        if (mem_req_addr !== line_a) begin
          n_err++;
          $display("FAIL %s req_stable: got %h expected %h", name, mem_req_addr, line_a);
        end
      end
      stalls++;
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (stalls != exp_stall) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
    end
    n_cmp++;
    if (reqc != exp_reqc) begin
      n_err++;
      $display("FAIL %s req_cycles: got %0d expected %0d", name, reqc, exp_reqc);
    end
    want = exp_instr_q.pop_front();
    n_cmp++;
    if (instr !== want) begin
      n_err++;
      $display("FAIL %s instr: got %h expected %h", name, instr, want);
    end
    exp_hits = exp_hits + 32'd1;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (cache_stall_or_not !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: stall=%b req_valid=%b req_addr=%h expected 0/0/0",
               cache_stall_or_not, mem_req_valid, mem_req_addr);
    end
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters: hits=%0d misses=%0d expected 0/0", hit_count, miss_count);
    end
    fetch_valid = 1'b1;
    pc_addr     = 32'h0;
    #1;
    n_cmp++;
    if (cache_stall_or_not !== 1'b1 || instr !== NOP_INSTR) begin
      n_err++;
      $display("FAIL reset_first_miss: stall=%b instr=%h expected 1/%h",
               cache_stall_or_not, instr, NOP_INSTR);
    end
    fetch_valid = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0000_0000, 5, 1, "cold_miss");
    n_cmp++;
    if (miss_count !== 32'd1 || miss_count !== exp_misses) begin
      n_err++;
      $display("FAIL cold_miss_count: got %0d expected 1", miss_count);
    end
  endtask

  task automatic test_spatial_hits();
    run_fetch(32'h0000_0004, 0, 0, "hit_4");
    run_fetch(32'h0000_0008, 0, 0, "hit_8");
    run_fetch(32'h0000_000C, 0, 0, "hit_c");
    n_cmp++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      n_err++;
      $display("FAIL spatial_counters: hits=%0d misses=%0d expected %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    run_fetch(32'h0000_0000, 5, 1, "conflict_a");
    run_fetch(32'h0000_0100, 5, 1, "conflict_b");
    run_fetch(32'h0000_0000, 5, 1, "conflict_a2");
    n_cmp++;
    if (miss_count !== 32'd3) begin
      n_err++;
      $display("FAIL conflict_misses: got %0d expected 3", miss_count);
    end
  endtask

  task automatic test_backpressure();
    hold_left = 4;
    run_fetch(32'h0000_0304, 9, 5, "backpressure");
    run_fetch(32'h0000_0300, 0, 0, "backpressure_hit");
    n_cmp++;
    if (miss_count !== exp_misses || hit_count !== exp_hits) begin
      n_err++;
      $display("FAIL backpressure_counters: hits=%0d misses=%0d expected %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset_in_wait();
    resp_delay = 4;
    exp_req_q.push_back(32'h0000_0200);
    fetch_valid = 1'b1;
    pc_addr     = 32'h0000_0208;
    #1;
    n_cmp++;
    if (cache_stall_or_not !== 1'b1) begin
      n_err++;
      $display("FAIL rw_detect: stall got %b expected 1", cache_stall_or_not);
    end
    tick();
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rw_req: req_valid got %b expected 1", mem_req_valid);
    end
    tick();
    reset       = 1'b1;
    fetch_valid = 1'b0;
    tick();
    reset      = 1'b0;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (cache_stall_or_not !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rw_after_reset[%0d]: stall=%b req_valid=%b expected 0/0",
                 c, cache_stall_or_not, mem_req_valid);
      end
      tick();
    end
    resp_delay = 2;
    run_fetch(32'h0000_0208, 5, 1, "rw_refetch");
    n_cmp++;
    if (miss_count !== 32'd1) begin
      n_err++;
      $display("FAIL rw_miss_count: got %0d expected 1", miss_count);
    end
  endtask

  task automatic test_bubble();
    for (int c = 0; c < 3; c++) begin
      fetch_valid = 1'b0;
      pc_addr     = 32'h0000_0400;
      #1;
      n_cmp++;
      if (cache_stall_or_not !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL bubble[%0d]: stall=%b req_valid=%b expected 0/0",
                 c, cache_stall_or_not, mem_req_valid);
      end
      tick();
    end
    n_cmp++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      n_err++;
      $display("FAIL bubble_counters: hits=%0d misses=%0d expected %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  initial begin
    reset       = 1'b1;
    fetch_valid = 1'b0;
    pc_addr     = 32'h0;
    exp_hits    = 32'd0;
    exp_misses  = 32'd0;
    tick();
    test_reset();
    test_cold_miss();
    test_spatial_hits();
    test_conflict();
    test_backpressure();
    test_reset_in_wait();
    test_bubble();
    n_cmp++;
    if (exp_req_q.size() != 0 || exp_instr_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d requests and %0d instructions left, expected 0",
               exp_req_q.size(), exp_instr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
